alu_ctrl_decode: RTL
====================

Name: alu_ctrl_decode

Overview:
- Registered ID-stage decoder that produces the ALU control interface (alu select, sign, shift) and operand steering for the rv32 pipeline EX stage.
- Accepts one RV32I instruction per cycle from fetch over a valid/ready handshake.
- Holds decoded fields in a single-entry ID/EX register with stall and flush support.

Parameters:
- XLEN, 32, datapath/immediate width; only 32 is supported.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  instruction valid from fetch
- o_ready  out  1  decoder can accept
- i_instr  in  32  instruction word
- i_pc  in  32  instruction PC
- i_flush  in  1  kill held/incoming instruction (branch redirect)
- o_valid  out  1  decoded bundle valid to EX
- i_ready  in  1  EX accepts bundle
- o_alu_sel  out  4  ALU operation select
- o_sign  out  1  signed compare/shift qualifier
- o_shift  out  1  operation is a shift
- o_op1_pc  out  1  operand 1 = PC (AUIPC, JAL)
- o_op2_imm  out  1  operand 2 = o_imm
- o_imm  out  32  sign/zero-extended immediate
- o_rs1, o_rs2, o_rd  out  5 each  register indices
- o_wb_en  out  1  rd writeback enable (0 when rd==0)
- o_pc  out  32  registered PC
- o_illegal  out  1  present only with the optional feature

Behaviour:
- Reset: asynchronous, active-high; o_valid=0 and all bundle outputs 0 immediately on i_rst, regardless of the clock. Any in-flight instruction is discarded.
- o_ready = !o_valid || i_ready (combinational). Load occurs when i_valid && o_ready; latency is 1 cycle from accept to o_valid.
- Load with no new instruction: o_valid <= i_valid && o_ready; the bundle holds whenever o_valid && !i_ready (stall). All outputs stay stable while stalled.
- Flush: i_flush has priority; next cycle o_valid=0 and no load occurs, even if i_valid=1 in the same cycle. Bundle contents after a flush are don't-care.
- ALU select encoding:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 ADD, 0100 SUB, 0101 SLT
  - 0110 PASS op2, 0111 SLL, 1000 SRL, 1001 SRA, 1011 SLTU
- OP (0110011): funct3/funct7[5] map to AND/OR/XOR/ADD/SUB/SLT/SLTU/SLL/SRL/SRA; o_op2_imm=0.
- OP-IMM (0010011): same mapping with I-imm and op2_imm=1, except funct3=000 is always ADD. Shifts use imm = zero-extended shamt instr[24:20]; funct7[5] selects SRAI.
- LUI: PASS op2, imm = instr[31:12]<<12.
- AUIPC: ADD, op1_pc=1, U-imm.
- LOAD/STORE/JALR: ADD with I/S-imm. STORE has wb_en=0.
- JAL: ADD, op1_pc=1, J-imm.
- BRANCH: BEQ/BNE→SUB; BLT/BGE→SLT; BLTU/BGEU→SLTU; B-imm; wb_en=0.
- o_sign=1 for SLT, SLTI, BLT, BGE, SRA, SRAI; otherwise 0.
- o_shift=1 for SLL/SRL/SRA and their immediate forms.
- Unknown opcode/funct: decodes to ADD, wb_en=0 (NOP).
- o_wb_en is forced to 0 when rd==0.

Optional Feature:
- Macro: ALU_DECODE_ILLEGAL_TRAP_EN
  - Defined: o_illegal port exists; set to 1 with the bundle for any unrecognised opcode/funct combination; the bundle is still NOP.
  - Undefined: no port; illegal encodings silently become NOP.

Decomposition:
- Package alu_pkg: ALU_* select localparams (the 4-bit encoding above) and OPC_* opcode constants. The ALU and this decoder share it.
- Sub-module imm_gen (combinational): instr → I/S/B/U/J immediates selected by format.
- Handshake register and decode tables remain in alu_ctrl_decode.

Test Plan:
- 0x002081B3 (ADD x3,x1,x2) accepted with i_ready=1 → next cycle o_valid=1, sel=0011, rs1=1, rs2=2, rd=3, op2_imm=0, wb_en=1.
- 0x40435293 (SRAI x5,x6,4) → sel=1001, sign=1, shift=1, op2_imm=1, imm=0x00000004, rd=5.
- 0x123453B7 (LUI x7,0x12345) → sel=0110, imm=0x12345000, wb_en=1.
- Bundle valid, i_ready=0 for 3 cycles with new i_valid → o_ready=0, outputs unchanged; i_ready=1 then loads the new instruction next cycle.
- i_flush=1 with i_valid=1 → o_valid=0 next cycle. i_rst pulse mid-stall → o_valid=0 without a clock edge.
- 0xFFFFFFFF → sel=0011, wb_en=0; o_illegal=1 when ALU_DECODE_ILLEGAL_TRAP_EN is defined.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU select encoding, RV32I opcode constants and decode-side types.
// Used by the ALU and by alu_ctrl_decode.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_PASS = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT
  } imm_fmt_e;

  typedef struct packed {
    logic [3:0]  alu_sel;
    logic        sign;
    logic        shift;
    logic        op1_pc;
    logic        op2_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wb_en;
    logic [31:0] pc;
  } bundle_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the I/S/B/U/J (or shift-amount)
// immediate out of the instruction word according to the decoded format.
module imm_gen
  import alu_pkg::*;
(
  input  logic [31:7] i_instr,
  input  imm_fmt_e    i_fmt,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_fmt)
      IMM_I:     o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:     o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:     o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U:     o_imm = {i_instr[31:12], 12'b0};
      IMM_J:     o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
      IMM_SHAMT: o_imm = {27'b0, i_instr[24:20]};
      default:   o_imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decode.sv
// Registered ID-stage decoder producing ALU control and operand steering for EX.
// Optional macro ALU_DECODE_ILLEGAL_TRAP_EN adds the o_illegal output.
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [3:0]      o_alu_sel,
  output logic            o_sign,
  output logic            o_shift,
  output logic            o_op1_pc,
  output logic            o_op2_imm,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic            o_wb_en,
`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
  output logic            o_illegal,
`endif
  output logic [XLEN-1:0] o_pc
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_zero, f7_alt;

  assign opcode  = i_instr[6:0];
  assign funct3  = i_instr[14:12];
  assign funct7  = i_instr[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  logic [3:0] sel;
  logic       sign, shift, op1_pc, op2_imm, wb_en, illegal;
  imm_fmt_e   fmt;
  logic [31:0] imm;

  always_comb begin
    sel     = ALU_ADD;
    sign    = 1'b0;
    shift   = 1'b0;
    op1_pc  = 1'b0;
    op2_imm = 1'b0;
    wb_en   = 1'b0;
    illegal = 1'b0;
    fmt     = IMM_NONE;
    case (opcode)
      OPC_OP: begin
        wb_en = 1'b1;
        case (funct3)
          3'b000: begin
            sel     = f7_alt ? ALU_SUB : ALU_ADD;
            illegal = !(f7_zero || f7_alt);
          end
          3'b001: begin sel = ALU_SLL;  shift = 1'b1; illegal = !f7_zero; end
          3'b010: begin sel = ALU_SLT;  sign = 1'b1;  illegal = !f7_zero; end
          3'b011: begin sel = ALU_SLTU; illegal = !f7_zero; end
          3'b100: begin sel = ALU_XOR;  illegal = !f7_zero; end
          3'b101: begin
            sel     = f7_alt ? ALU_SRA : ALU_SRL;
            sign    = f7_alt;
            shift   = 1'b1;
            illegal = !(f7_zero || f7_alt);
          end
          3'b110: begin sel = ALU_OR;  illegal = !f7_zero; end
          default: begin sel = ALU_AND; illegal = !f7_zero; end
        endcase
      end
      OPC_OPIMM: begin
        wb_en   = 1'b1;
        op2_imm = 1'b1;
        fmt     = IMM_I;
        case (funct3)
          3'b000: sel = ALU_ADD;
          3'b001: begin
            sel = ALU_SLL; shift = 1'b1; fmt = IMM_SHAMT; illegal = !f7_zero;
          end
          3'b010: begin sel = ALU_SLT; sign = 1'b1; end
          3'b011: sel = ALU_SLTU;
          3'b100: sel = ALU_XOR;
          3'b101: begin
            sel     = f7_alt ? ALU_SRA : ALU_SRL;
            sign    = f7_alt;
            shift   = 1'b1;
            fmt     = IMM_SHAMT;
            illegal = !(f7_zero || f7_alt);
          end
          3'b110: sel = ALU_OR;
          default: sel = ALU_AND;
        endcase
      end
      OPC_LUI:   begin sel = ALU_PASS; op2_imm = 1'b1; wb_en = 1'b1; fmt = IMM_U; end
      OPC_AUIPC: begin op1_pc = 1'b1; op2_imm = 1'b1; wb_en = 1'b1; fmt = IMM_U; end
      OPC_JAL:   begin op1_pc = 1'b1; op2_imm = 1'b1; wb_en = 1'b1; fmt = IMM_J; end
      OPC_JALR:  begin op2_imm = 1'b1; wb_en = 1'b1; fmt = IMM_I; illegal = (funct3 != 3'b000); end
      OPC_LOAD: begin
        op2_imm = 1'b1; wb_en = 1'b1; fmt = IMM_I;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin op2_imm = 1'b1; fmt = IMM_S; illegal = (funct3 > 3'b010); end
      OPC_BRANCH: begin
        fmt = IMM_B;
        case (funct3[2:1])
          2'b00:   sel = ALU_SUB;
          2'b10:   begin sel = ALU_SLT; sign = 1'b1; end
          2'b11:   sel = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    // Anything unrecognised collapses to a NOP: ADD, no writeback, no steering.
    if (illegal) begin
      sel     = ALU_ADD;
      sign    = 1'b0;
      shift   = 1'b0;
      op1_pc  = 1'b0;
      op2_imm = 1'b0;
      wb_en   = 1'b0;
      fmt     = IMM_NONE;
    end
  end

  imm_gen u_imm_gen (
    .i_instr (i_instr[31:7]),
    .i_fmt   (fmt),
    .o_imm   (imm)
  );

  bundle_t bundle_q, bundle_d, bundle_new;
  logic    valid_q, valid_d;

  always_comb begin
    bundle_new         = '0;
    bundle_new.alu_sel = sel;
    bundle_new.sign    = sign;
    bundle_new.shift   = shift;
    bundle_new.op1_pc  = op1_pc;
    bundle_new.op2_imm = op2_imm;
    bundle_new.imm     = imm;
    bundle_new.rs1     = i_instr[19:15];
    bundle_new.rs2     = i_instr[24:20];
    bundle_new.rd      = i_instr[11:7];
    bundle_new.wb_en   = wb_en && (i_instr[11:7] != 5'd0);
    bundle_new.pc      = i_pc;
  end

  assign o_ready = !valid_q || i_ready;

  // Flush wins over both the held bundle and any instruction offered this cycle.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (o_ready) begin
      valid_d = i_valid;
      if (i_valid) bundle_d = bundle_new;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (!i_flush && o_ready && i_valid) illegal_d = illegal;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign o_illegal = illegal_q;
`endif

  assign o_valid   = valid_q;
  assign o_alu_sel = bundle_q.alu_sel;
  assign o_sign    = bundle_q.sign;
  assign o_shift   = bundle_q.shift;
  assign o_op1_pc  = bundle_q.op1_pc;
  assign o_op2_imm = bundle_q.op2_imm;
  assign o_imm     = bundle_q.imm;
  assign o_rs1     = bundle_q.rs1;
  assign o_rs2     = bundle_q.rs2;
  assign o_rd      = bundle_q.rd;
  assign o_wb_en   = bundle_q.wb_en;
  assign o_pc      = bundle_q.pc;

endmodule
